// File: rtl/shift_reg_seq.sv
// shift_reg_seq: parametrised multi-mode shift register with a built-in
// shift sequencer. A single start command either loads the register or
// shifts/rotates it by a programmable amount over several cycles, with a
// busy/done handshake reporting progress.
//
// Optional feature macro: SHIFT_REG_SEQ_BYTE_STEP_EN
//   defined   : each SHIFT-state edge moves LANE positions while the remaining
//               count is >= LANE, otherwise 1 position.
//   undefined : strictly 1 bit position per SHIFT-state edge.
//
// Handshake: start is sampled only while the sequencer is IDLE; a command
// seen while busy is dropped, not queued. A multi-cycle command raises busy
// on the accepting edge and holds it for exactly as many cycles as steps
// are needed. done is a single-cycle pulse in the cycle after the command
// completes, and the final register value is visible in that same cycle.
// busy and done are never high together. Because the sequencer is already
// IDLE while done is high, a new start in the done cycle is accepted.

module shift_reg_seq #(
  parameter int WIDTH   = 64,
  parameter int LANE    = 8,
  parameter int SHAMT_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               fill_bit,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  // Command encodings on the mode input.
  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SAR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

`ifdef SHIFT_REG_SEQ_BYTE_STEP_EN
  localparam bit BYTE_STEP_EN = 1'b1;
`else
  localparam bit BYTE_STEP_EN = 1'b0;
`endif

  localparam logic [SHAMT_W-1:0] LANE_AMT = SHAMT_W'(LANE);
  localparam logic [SHAMT_W-1:0] ONE_AMT  = SHAMT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] remaining_q, remaining_d;

  // Intermediate values of a single SHIFT-state step.
  logic               lane_step;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] remaining_next;
  logic [WIDTH-1:0]   data_step;

  // One bit position of movement for the latched mode; reserved codes hold.
  function automatic logic [WIDTH-1:0] step_one(
    input logic [WIDTH-1:0] q,
    input logic [2:0]       m,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (m)
      MODE_SHL: r = {q[WIDTH-2:0], fill};
      MODE_SHR: r = {fill, q[WIDTH-1:1]};
      MODE_SAR: r = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_ROL: r = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: r = {q[0], q[WIDTH-1:1]};
      default:  r = q;
    endcase
    return r;
  endfunction

  // Datapath of one SHIFT-state edge: a lane-sized jump when enabled and
  // enough positions remain, else a single position. The lane jump is built
  // as LANE chained single steps so fill/sign/rotate rules apply per bit.
  always_comb begin
    lane_step = BYTE_STEP_EN && (remaining_q >= LANE_AMT);
    step_amt  = lane_step ? LANE_AMT : ONE_AMT;
    data_step = data_q;
    for (int i = 0; i < LANE; i++) begin
      if (lane_step || (i == 0)) begin
        data_step = step_one(data_step, mode_q, fill_bit);
      end
    end
    remaining_next = remaining_q - step_amt;
  end

  // Sequencer next-state: accept commands in IDLE, step and count in SHIFT.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          case (mode)
            MODE_LOAD: begin
              data_d = data_in;
              done_d = 1'b1;
            end
            MODE_SHL, MODE_SHR, MODE_SAR, MODE_ROL, MODE_ROR: begin
              if (amount == '0) begin
                done_d = 1'b1;
              end else begin
                mode_d      = mode;
                remaining_d = amount;
                busy_d      = 1'b1;
                state_d     = ST_SHIFT;
              end
            end
            default: begin
              // Reserved modes complete immediately as no-ops.
              done_d = 1'b1;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        data_d      = data_step;
        remaining_d = remaining_next;
        if (remaining_next == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        remaining_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= MODE_LOAD;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Testbench for shift_reg_seq: directed steps followed by random commands,
// each checked against a behavioural model of the command result and of the
// number of busy cycles. Honours SHIFT_REG_SEQ_BYTE_STEP_EN for cycle counts.

module tb_shift_reg_seq;

  localparam int W  = 64;
  localparam int L  = 8;
  localparam int SW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [SW-1:0] amount;
  logic [W-1:0]  data_in;
  logic          fill_bit;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] model_q;
  logic [W-1:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  shift_reg_seq #(.WIDTH(W), .LANE(L), .SHAMT_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .data_in  (data_in),
    .fill_bit (fill_bit),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result of a whole command, from the arithmetic meaning of each mode.
  function automatic logic [W-1:0] ref_result(input logic [2:0] m, input int amt,
                                              input logic [W-1:0] q, input logic [W-1:0] din,
                                              input logic fl);
    logic [W-1:0] ones;
    int r;
    ones = '1;
    r = amt % W;
    case (m)
      3'd0: return din;
      3'd1: return (amt >= W) ? {W{fl}} : ((q << amt) | (fl ? ~(ones << amt) : '0));
      3'd2: return (amt >= W) ? {W{fl}} : ((q >> amt) | (fl ? ~(ones >> amt) : '0));
      3'd3: return (amt >= W) ? {W{q[W-1]}} : W'($signed(q) >>> amt);
      3'd4: return (r == 0) ? q : ((q << r) | (q >> (W - r)));
      3'd5: return (r == 0) ? q : ((q >> r) | (q << (W - r)));
      default: return q;
    endcase
  endfunction

  // Number of cycles busy should be high for a command.
  function automatic int ref_cycles(input logic [2:0] m, input int amt);
    if (m == 3'd0 || m > 3'd5 || amt == 0) return 0;
`ifdef SHIFT_REG_SEQ_BYTE_STEP_EN
    return (amt / L) + (amt % L);
`else
    return amt;
`endif
  endfunction

  // Driver: called at a falling edge; issues one command, scrambles the
  // command inputs while busy, then checks the done pulse and result.
  // With chain set it returns in the done cycle so the next command can be
  // issued back-to-back.
  task automatic run_cmd(input string tag, input logic [2:0] m, input int amt,
                         input logic [W-1:0] din, input logic fl, input bit chain);
    logic [W-1:0] exp_d;
    int exp_c, cnt, guard;
    bit overlap;
    exp_d = ref_result(m, amt, model_q, din, fl);
    exp_c = ref_cycles(m, amt);
    exp_q.push_back(exp_d);
    start = 1'b1; mode = m; amount = amt[SW-1:0]; data_in = din; fill_bit = fl;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; guard = 0; overlap = 1'b0;
    while (done !== 1'b1 && guard < 400) begin
      if (busy === 1'b1) begin
        cnt++;
        start   = 1'($urandom_range(0, 1));
        mode    = 3'($urandom_range(0, 7));
        amount  = SW'($urandom);
        data_in = {$urandom, $urandom};
      end
      @(negedge clk);
      guard++;
      if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
    end
    start = 1'b0;
    check({tag, " done"}, W'(done), W'(1));
    check({tag, " busy_at_done"}, W'(busy), W'(0));
    check({tag, " overlap"}, W'(overlap), W'(0));
    check({tag, " busy_cycles"}, W'(cnt), W'(exp_c));
    check({tag, " data"}, data_out, exp_q.pop_front());
    model_q = exp_d;
    if (!chain) begin
      @(negedge clk);
      check({tag, " done_one_cycle"}, W'(done), W'(0));
      check({tag, " hold"}, data_out, exp_d);
    end
  endtask

  initial begin
    // reset block
    rst = 1'b1; start = 1'b0; mode = 3'd0; amount = '0; data_in = '0; fill_bit = 1'b0;
    model_q = '0;
    repeat (3) @(negedge clk);
    check("rst data", data_out, '0);
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst data", data_out, '0);
    check("post_rst done", W'(done), W'(0));

    // asynchronous reset during a 10-step shift
    run_cmd("load_a", 3'd0, 0, 64'hDEAD_BEEF_0000_1111, 1'b0, 1'b0);
    start = 1'b1; mode = 3'd1; amount = SW'(10); fill_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_shift busy", W'(busy), W'(1));
    #2 rst = 1'b1;
    #1;
    check("async data", data_out, '0);
    check("async busy", W'(busy), W'(0));
    check("async done", W'(done), W'(0));
    @(negedge clk);
    rst = 1'b0;
    model_q = '0;
    repeat (3) @(negedge clk);
    check("no_resume busy", W'(busy), W'(0));
    check("no_resume data", data_out, '0);

    // directed commands
    run_cmd("load1", 3'd0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    run_cmd("shl4", 3'd1, 4, '0, 1'b0, 1'b0);
    check("shl4 value", data_out, 64'h1234_5678_9ABC_DEF0);
    run_cmd("load2", 3'd0, 0, 64'h8000_0000_0000_0010, 1'b0, 1'b0);
    run_cmd("sar4", 3'd3, 4, '0, 1'b0, 1'b0);
    check("sar4 value", data_out, 64'hF800_0000_0000_0001);
    run_cmd("load3", 3'd0, 0, 64'h8000_0000_0000_0010, 1'b0, 1'b0);
    run_cmd("shr4f1", 3'd2, 4, '0, 1'b1, 1'b0);
    check("shr4f1 value", data_out, 64'hF800_0000_0000_0001);
    run_cmd("load4", 3'd0, 0, 64'h1, 1'b0, 1'b0);
    run_cmd("ror65", 3'd5, 65, '0, 1'b0, 1'b0);
    check("ror65 value", data_out, 64'h8000_0000_0000_0000);
    run_cmd("rol8", 3'd4, 8, '0, 1'b0, 1'b1);
    run_cmd("b2b_load", 3'd0, 0, 64'hFF, 1'b0, 1'b0);
    check("b2b value", data_out, 64'hFF);
    run_cmd("zero_amt", 3'd1, 0, '0, 1'b1, 1'b0);
    run_cmd("reserved6", 3'd6, 9, '1, 1'b1, 1'b0);
    run_cmd("reserved7", 3'd7, 3, '1, 1'b0, 1'b0);
    run_cmd("load5", 3'd0, 0, 64'h1, 1'b0, 1'b0);
    run_cmd("shl19", 3'd1, 19, '0, 1'b0, 1'b0);
    check("shl19 value", data_out, 64'h80000);
    run_cmd("sar127", 3'd3, 127, '0, 1'b0, 1'b0);
    run_cmd("load6", 3'd0, 0, 64'h7FFF_0000_1234_8000, 1'b0, 1'b0);
    run_cmd("shr100", 3'd2, 100, '0, 1'b1, 1'b0);
    check("shr100 value", data_out, '1);

    // random commands
    for (int i = 0; i < 40; i++) begin
      logic [2:0] rm;
      int ra;
      rm = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 20);
      run_cmd($sformatf("rand%0d", i), rm, ra, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
Parametrised multi-mode shift register with a built-in shift sequencer. It generalises the fixed 64-bit, 8-lane, one-step shift/load register to any width. A single start command loads the register or shifts/rotates it by a programmable amount over several cycles, and the block reports progress with a busy/done handshake. It serves as the shift/rotate engine behind PC and datapath registers.

Parameters:
WIDTH, 64, register width in bits; must be a multiple of LANE
LANE, 8, lane width in bits; used only for the byte-step feature
SHAMT_W, 7, shift-amount width; must satisfy 2**SHAMT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous active-high reset
start  input  1  command strobe; sampled only while in IDLE
mode  input  3  000 load, 001 SHL logical, 010 SHR logical, 011 SAR arithmetic, 100 ROL, 101 ROR, 110/111 reserved
amount  input  SHAMT_W  number of bit positions to shift or rotate
data_in  input  WIDTH  parallel load value (mode 000)
fill_bit  input  1  bit shifted into the vacated position for SHL/SHR
data_out  output  WIDTH  register contents
busy  output  1  high while a multi-cycle shift is in progress
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, any time including mid-shift): data_out=0, busy=0, done=0, state=IDLE, remaining count=0. A command in progress is aborted and not resumed.
- FSM has two states: IDLE and SHIFT.
- IDLE, start=0: hold data_out. done is 0 in the next cycle.
- IDLE, start=1, mode=000: data_out<=data_in at this edge. done=1 for the next cycle. busy stays 0. amount is ignored.
- IDLE, start=1, shift/rotate mode, amount=0: data_out unchanged. done=1 next cycle. busy stays 0.
- IDLE, start=1, mode 110/111: treated as a no-op. data_out unchanged, done=1 next cycle.
- IDLE, start=1, shift/rotate mode, amount=N>0:
  - mode and N are latched at this edge (edge k); busy<=1; state<=SHIFT.
  - Later changes on mode, amount, data_in and start are ignored until the command completes.
- SHIFT state, each edge: perform a 1-bit step and decrement remaining.
  - SHL: {q[WIDTH-2:0], fill_bit}
  - SHR: {fill_bit, q[WIDTH-1:1]}
  - SAR: {q[WIDTH-1], q[WIDTH-1:1]}
  - ROL: {q[WIDTH-2:0], q[WIDTH-1]}
  - ROR: {q[0], q[WIDTH-1:1]}
  - fill_bit is sampled live on every step.
- Completion: the last step happens at edge k+N. That edge sets busy<=0, done<=1 for exactly one cycle, state<=IDLE. busy is high for exactly N cycles. Final data_out is valid in the same cycle that done is high.
- amount>WIDTH is legal and iterates fully. SHL/SHR saturate to all fill_bit. SAR saturates to all sign. Rotates wrap modulo WIDTH.
- start while busy: ignored, not queued.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted, because the state is IDLE.
- busy and done are never high in the same cycle.

Optional Feature:
Macro: SHIFT_REG_SEQ_BYTE_STEP_EN.
- Defined: each SHIFT-state edge moves LANE positions while remaining>=LANE, otherwise 1 position. Fill, sign and rotate rules apply per moved bit. A command with amount N takes floor(N/LANE) + (N mod LANE) cycles, with the same busy/done timing rules.
- Undefined: strictly 1 bit per cycle. The LANE parameter has no effect.

Test Plan:
1. Reset with rst=1, then release -> data_out=0, busy=0, done=0. Assert rst during a 10-step shift -> all outputs 0 immediately (async, before the next clk edge).
2. Load 64'h0123_4567_89AB_CDEF, then SHL amount=4 with fill_bit=0 -> busy high 4 cycles, done pulses once, data_out=64'h1234_5678_9ABC_DEF0.
3. Load 64'h8000_0000_0000_0010, then SAR amount=4 -> 64'hF800_0000_0000_0001. Repeat with SHR, fill_bit=1 -> same result.
4. Load 64'h0000_0000_0000_0001, then ROR amount=65 -> busy for 65 cycles, data_out=64'h8000_0000_0000_0000.
5. During a ROL amount=8, pulse start with mode=000 -> pulse ignored. When done asserts, issue a load 64'hFF in that same cycle -> data_out=64'hFF one cycle later, with a fresh done pulse.
6. With SHIFT_REG_SEQ_BYTE_STEP_EN defined: SHL amount=19 on 64'h1 -> busy for 5 cycles, data_out=64'h80000. Undefined: same command -> busy for 19 cycles, same result.
